if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It takes the current PC and fetches the instruction over a req/ack instruction-memory interface. It drives the PC register's hold input and produces the IF/ID pipeline register contents (valid, pc, pc+4, instruction) for decode. It handles variable memory latency, decode stalls, and branch/jump redirect flushes, including redirects that arrive while a fetch is still outstanding.

Parameters:
ADDR_W, 32, PC / instruction address width
INST_W, 32, instruction width
NOP_INST, 32'h00000000, instruction value presented when id_valid=0

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
pc_i  in  ADDR_W  current PC from the PC register
pc_hold  out  1  to the PC register enable; 1 = hold PC, 0 = load next PC (combinational)
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  fetch address; stable while imem_req=1
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  INST_W  instruction data, valid when imem_ack=1
redirect  in  1  branch/jump taken (from EX); flush IF/ID and discard in-flight fetch
stall_id  in  1  hazard unit requests IF/ID hold
id_valid  out  1  IF/ID holds a live instruction
id_pc  out  ADDR_W  PC of the IF/ID instruction
id_pc4  out  ADDR_W  id_pc + 4
id_inst  out  INST_W  IF/ID instruction (NOP_INST when not valid)

Behaviour:
- Internal registers: state, req_addr, buf_inst.
- Reset values: state=ISSUE, req_addr=0, buf_inst=NOP_INST, id_valid=0, id_pc=0, id_pc4=0, id_inst=NOP_INST. Combinational outputs under reset: imem_req=0, pc_hold=1.
- Reset mid-operation abandons any outstanding request without waiting for its ack.
- imem_addr = req_addr at all times. imem_req=1 only in WAIT and DROP.
- accept = !id_valid || !stall_id.
- States and transitions:
  - ISSUE: req_addr <= pc_i; go to WAIT. The redirect target loads into the PC in this cycle, because of the pc_hold rule below.
  - WAIT:
    - ack && redirect -> data discarded; go to ISSUE.
    - ack && accept -> IF/ID <= {1, req_addr, req_addr+4, imem_rdata}; pc_hold=0; go to ISSUE.
    - ack && !accept -> buf_inst <= imem_rdata; go to BUF.
    - no ack && redirect -> go to DROP.
    - otherwise stay in WAIT.
  - DROP: keep the request; on ack discard the data and go to ISSUE. A further redirect here stays in DROP.
  - BUF (no request issued):
    - redirect -> go to ISSUE, buf discarded.
    - !stall_id -> IF/ID <= {1, req_addr, req_addr+4, buf_inst}; pc_hold=0; go to ISSUE.
- pc_hold = 0 exactly when an instruction is delivered to IF/ID or redirect=1; otherwise 1. The PC therefore advances once per delivered instruction and always takes a redirect target.
- IF/ID register priority: Reset > redirect (id_valid<=0, id_inst<=NOP_INST, id_pc and id_pc4 unchanged) > load > hold (stall_id with id_valid=1 keeps all fields).
- Arithmetic: id_pc4 = req_addr + 4 modulo 2^ADDR_W, so 32'hFFFFFFFC gives 0.
- Throughput: with zero-wait memory (ack on the first WAIT cycle), one instruction every 2 cycles.
- An ack outside WAIT/DROP is a protocol error and is ignored.

Decomposition:
- Shared pipeline package holds:
  - state encoding localparams (ISSUE=2'd0, WAIT=2'd1, BUF=2'd2, DROP=2'd3)
  - NOP_INST constant
  - the pc-increment constant 4
- No sub-module. The FSM, skid buffer, and IF/ID register stay in one file.

Test Plan:
- Reset held 2 cycles -> id_valid=0, id_inst=NOP_INST, imem_req=0, pc_hold=1. First WAIT issues imem_addr=pc_i=0.
- Zero-wait memory, pc 0x0/0x4/0x8, no stalls -> id_pc 0x0, 0x4, 0x8 every 2 cycles; id_pc4 = id_pc+4; pc_hold low exactly one cycle per instruction.
- 3-cycle ack latency -> imem_req high with addr stable for 3 cycles; pc_hold=1 throughout; one IF/ID load on ack.
- stall_id=1 with id_valid=1 while ack arrives with data 0x12345678 -> state BUF, IF/ID unchanged. When stall_id drops -> id_inst=0x12345678 next cycle and pc_hold=0 that cycle.
- redirect asserted in WAIT before ack, ack arriving 2 cycles later -> DROP, id_valid=0; the acked data never appears on id_inst; next request uses the redirect target PC.
- req_addr=32'hFFFFFFFC fetched -> id_pc4=0. Reset asserted in WAIT -> imem_req=0 next cycle and state ISSUE.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state encoding,
// the default NOP instruction and the PC increment.
package if_fetch_stage_pkg;

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BUF   = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues req/ack fetches for the current PC, buffers a
// returned instruction while decode stalls, and squashes fetches on redirect.
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(if_fetch_stage_pkg::NOP_INST)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_hold,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic              stall_id,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
  output logic [INST_W-1:0] id_inst
);
  import if_fetch_stage_pkg::*;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] buf_inst;
  logic              accept, deliver, capture;

  assign accept    = !id_valid || !stall_id;
  assign imem_addr = req_addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (Reset) state <= ISSUE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (imem_ack) begin
          if (redirect || accept) state_nxt = ISSUE;
          else                    state_nxt = BUF;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      BUF:  if (redirect || !stall_id) state_nxt = ISSUE;
      DROP: if (imem_ack) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  // Output decode; a redirect always wins over delivery of the current fetch.
  always_comb begin
    deliver  = 1'b0;
    capture  = 1'b0;
    imem_req = !Reset && ((state == WAIT) || (state == DROP));
    case (state)
      WAIT: begin
        deliver = imem_ack && !redirect && accept;
        capture = imem_ack && !redirect && !accept;
      end
      BUF:     deliver = !redirect && !stall_id;
      default: ;
    endcase
    pc_hold = Reset || !(deliver || redirect);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      req_addr <= '0;
      buf_inst <= NOP_INST;
    end else begin
      if (state == ISSUE) req_addr <= pc_i;
      if (capture)        buf_inst <= imem_rdata;
    end
  end

  // IF/ID register: an unstalled decode consumes the entry, leaving a bubble.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_inst  <= NOP_INST;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (deliver) begin
      id_valid <= 1'b1;
      id_pc    <= req_addr;
      id_pc4   <= req_addr + ADDR_W'(PC_INC);
      id_inst  <= (state == BUF) ? buf_inst : imem_rdata;
    end else if (accept) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a transaction-level fetch model, a
// variable-latency memory and a PC register drive and predict every cycle.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_hold, imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, stall_id = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_inst;

  if_fetch_stage dut (
    .CLK(CLK), .Reset(Reset), .pc_i(pc_i), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .stall_id(stall_id),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < 32'(p);
  endfunction

  // Model: a fetch is either about to be launched, outstanding (possibly
  // doomed by a redirect), or parked in a skid slot behind a stalled decode.
  bit          m_launch = 1'b1;
  bit          m_outst  = 1'b0;
  bit          m_doomed = 1'b0;
  bit          m_skid   = 1'b0;
  logic [31:0] m_skid_data = NOP;
  logic [31:0] m_addr = '0;
  bit          m_idv = 1'b0;
  logic [31:0] m_idpc = '0, m_idpc4 = '0, m_idinst = NOP;
  logic [31:0] pc = '0;
  int unsigned lat = 0;

  task automatic run_cycle(input bit force_rst, input int lat_lo, input int lat_hi,
                           input int stall_pct, input int redir_pct, input int rst_pct);
    bit          rst, stall, redir, ack, accept, deliver, exp_hold;
    logic [31:0] target, rdata;
    int          pick;

    rst   = force_rst || pct(rst_pct);
    stall = pct(stall_pct);
    redir = pct(redir_pct);
    pick  = int'($urandom_range(3));
    target = (pick == 0) ? 32'hFFFF_FFFC :
             (pick == 1) ? {24'h0, $urandom_range(255) & 32'h0000_00FC} :
                           ($urandom & 32'hFFFF_FFFC);
    if (m_outst) begin
      ack = (lat == 0);
      if (lat != 0) lat--;
    end else begin
      ack = pct(8);
    end
    rdata = $urandom;

    Reset = rst; stall_id = stall; redirect = redir;
    imem_ack = ack; imem_rdata = rdata;
    #1;

    accept   = !m_idv || !stall;
    deliver  = !rst && !redir &&
               ((m_outst && !m_doomed && ack && accept) || (m_skid && !stall));
    exp_hold = rst || !(deliver || redir);

    check("pc_hold",   32'(pc_hold),  32'(exp_hold));
    check("imem_req",  32'(imem_req), 32'(!rst && m_outst));
    check("imem_addr", imem_addr, m_addr);
    check("id_valid",  32'(id_valid), 32'(m_idv));
    check("id_pc",     id_pc,   m_idpc);
    check("id_pc4",    id_pc4,  m_idpc4);
    check("id_inst",   id_inst, m_idinst);

    @(posedge CLK);
    #1;
    if (rst) begin
      m_launch = 1'b1; m_outst = 1'b0; m_doomed = 1'b0; m_skid = 1'b0;
      m_addr = '0; m_idv = 1'b0; m_idpc = '0; m_idpc4 = '0; m_idinst = NOP;
      pc = '0;
    end else begin
      if (redir) begin
        m_idv = 1'b0; m_idinst = NOP;
      end else if (deliver) begin
        m_idv    = 1'b1;
        m_idpc   = m_addr;
        m_idpc4  = m_addr + 32'd4;
        m_idinst = m_skid ? m_skid_data : rdata;
      end else if (accept) begin
        m_idv = 1'b0; m_idinst = NOP;
      end

      if (m_launch) begin
        m_addr = pc_i; m_outst = 1'b1; m_doomed = 1'b0; m_launch = 1'b0;
        lat = $urandom_range(lat_hi, lat_lo);
      end else if (m_outst) begin
        if (ack) begin
          m_outst = 1'b0;
          if (!m_doomed && !redir && !accept) begin
            m_skid = 1'b1; m_skid_data = rdata;
          end else begin
            m_launch = 1'b1;
          end
        end else if (redir) begin
          m_doomed = 1'b1;
        end
      end else if (m_skid && (redir || !stall)) begin
        m_skid = 1'b0; m_launch = 1'b1;
      end

      if (!exp_hold) pc = redir ? target : pc + 32'd4;
    end
    pc_i = pc;
    @(negedge CLK);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // Reset held two checked cycles, then zero-wait streaming.
    repeat (2)   run_cycle(1'b1, 0, 0, 0, 0, 0);
    repeat (20)  run_cycle(1'b0, 0, 0, 0, 0, 0);
    // Fixed three-cycle latency, including a reset landing mid-fetch.
    repeat (15)  run_cycle(1'b0, 2, 2, 0, 0, 0);
    repeat (2)   run_cycle(1'b0, 2, 2, 0, 0, 0);
    run_cycle(1'b1, 2, 2, 0, 0, 0);
    repeat (12)  run_cycle(1'b0, 2, 2, 0, 0, 0);
    // Stalls only, exercising the skid buffer.
    repeat (100) run_cycle(1'b0, 0, 3, 40, 0, 0);
    // Redirects during long fetches, exercising the discard path.
    repeat (150) run_cycle(1'b0, 1, 4, 10, 15, 0);
    // Everything mixed, with occasional resets.
    repeat (600) run_cycle(1'b0, 0, 4, 35, 10, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
